// File: rtl/timer_sched_pkg.sv
// Shared state encoding and default sizing for the timer scheduler.
package timer_sched_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester selection for the timer scheduler.
// Build option TIMER_SCHED_FIXED_PRIO_EN: lowest index always wins, i_ptr ignored.
module rr_arbiter
  import timer_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned PW   = $clog2(NREQ)
)(
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt_c,
  output logic            o_valid_c
);

  assign o_valid_c = |i_req;

`ifdef TIMER_SCHED_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_gnt_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (i_req[i] && (o_gnt_c == '0)) o_gnt_c[i] = 1'b1;
    end
  end
`else
  int unsigned w_idx;

  // Walk the requesters starting at i_ptr, wrapping at NREQ; first hit wins.
  always_comb begin
    o_gnt_c = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = 32'(i_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (i_req[PW'(w_idx)] && (o_gnt_c == '0)) o_gnt_c[PW'(w_idx)] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/timer_scheduler.sv
// Shares one countdown timer between NREQ requesters, one timed grant at a time.
// Build option TIMER_SCHED_FIXED_PRIO_EN: fixed priority instead of round-robin.
module timer_scheduler
  import timer_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned W    = W_DEF
)(
  input  logic              CLK,
  input  logic              N_RESET,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*W-1:0] DUR,
  input  logic              ABORT,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   DONE,
  output logic              BUSY
);

  localparam int unsigned PW = $clog2(NREQ);

  sched_state_t    r_state, w_state_nxt;
  logic [W-1:0]    r_count, w_count_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic            r_busy, w_busy_nxt;

  logic [NREQ-1:0] w_arb_gnt;
  logic            w_arb_valid;
  logic [W-1:0]    w_win_dur;
  logic [W-1:0]    w_load;
  logic [PW-1:0]   w_ptr_adv;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .i_req     (REQ),
    .i_ptr     (r_ptr),
    .o_gnt_c   (w_arb_gnt),
    .o_valid_c (w_arb_valid)
  );

  // Winner's duration and the pointer position just past the winner.
  always_comb begin
    w_win_dur = '0;
    w_ptr_adv = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_win_dur = DUR[i*W +: W];
`ifndef TIMER_SCHED_FIXED_PRIO_EN
        w_ptr_adv = (i == NREQ - 1) ? '0 : PW'(i + 1);
`endif
      end
    end
  end

  // A zero duration still runs for one cycle.
  assign w_load = (w_win_dur == '0) ? '0 : w_win_dur - W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_count_nxt = w_load;
          w_gnt_nxt   = w_arb_gnt;
          w_ptr_nxt   = w_ptr_adv;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (ABORT) begin
          w_gnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (r_count == '0) begin
          w_gnt_nxt   = '0;
          w_done_nxt  = r_gnt;
          w_state_nxt = FIN;
        end else begin
          w_count_nxt = r_count - W'(1);
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      r_state <= IDLE;
      r_count <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign GNT  = r_gnt;
  assign DONE = r_done;
  assign BUSY = r_busy;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed self-checking bench for timer_scheduler (NREQ=4, W=8).
module tb_timer_scheduler;

  logic        CLK;
  logic        N_RESET;
  logic [3:0]  REQ;
  logic [31:0] DUR;
  logic        ABORT;
  logic [3:0]  GNT;
  logic [3:0]  DONE;
  logic        BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  timer_scheduler #(.NREQ(4), .W(8)) dut (
    .CLK     (CLK),
    .N_RESET (N_RESET),
    .REQ     (REQ),
    .DUR     (DUR),
    .ABORT   (ABORT),
    .GNT     (GNT),
    .DONE    (DONE),
    .BUSY    (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_idle();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (!BUSY) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_idle: BUSY=%b after 40 cycles, want 0", BUSY);
    end
  endtask

  task automatic test_reset();
    REQ = 4'b1111; DUR = 32'h03030303; ABORT = 1'b0; N_RESET = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_checks++;
      if ({GNT, DONE, BUSY} !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d: GNT=%b DONE=%b BUSY=%b, want 0000 0000 0", c, GNT, DONE, BUSY);
      end
    end
    N_RESET = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({GNT, DONE, BUSY} !== {4'b0001, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_first_grant: GNT=%b DONE=%b BUSY=%b, want 0001 0000 1", GNT, DONE, BUSY);
    end
    REQ = 4'b0000;
  endtask

  task automatic test_single();
    logic [3:0] eg, ed;
    logic       eb;
    REQ = 4'b0100; DUR = 32'h00050000;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      eg = (c < 5) ? 4'b0100 : 4'b0000;
      ed = (c == 5) ? 4'b0100 : 4'b0000;
      eb = (c < 6);
      n_checks++;
      if ({GNT, DONE, BUSY} !== {eg, ed, eb}) begin
        n_fail++;
        $display("FAIL single c=%0d: GNT=%b DONE=%b BUSY=%b, want %b %b %b", c, GNT, DONE, BUSY, eg, ed, eb);
      end
      if (c == 0) REQ = 4'b0000;
    end
  endtask

  task automatic test_rr();
    int         ord[5] = '{0, 1, 2, 3, 0};
    int         w, ph;
    logic [3:0] eg, ed;
    logic       eb;
    N_RESET = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({GNT, DONE, BUSY} !== 9'b0) begin
      n_fail++;
      $display("FAIL rr_reset: GNT=%b DONE=%b BUSY=%b, want 0000 0000 0", GNT, DONE, BUSY);
    end
    N_RESET = 1'b1; REQ = 4'b1111; DUR = 32'h03030303;
    for (int c = 0; c < 25; c++) begin
      @(negedge CLK);
      w  = ord[c / 5];
      ph = c % 5;
      eg = (ph < 3) ? (4'b0001 << w) : 4'b0000;
      ed = (ph == 3) ? (4'b0001 << w) : 4'b0000;
      eb = (ph < 4);
      n_checks++;
      if ({GNT, DONE, BUSY} !== {eg, ed, eb}) begin
        n_fail++;
        $display("FAIL round_robin c=%0d: GNT=%b DONE=%b BUSY=%b, want %b %b %b", c, GNT, DONE, BUSY, eg, ed, eb);
      end
      if (c == 20) REQ = 4'b0000;
    end
  endtask

  task automatic test_dur0();
    logic [3:0] eg, ed;
    logic       eb;
    REQ = 4'b0010; DUR = 32'h00000000;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      eg = (c == 0) ? 4'b0010 : 4'b0000;
      ed = (c == 1) ? 4'b0010 : 4'b0000;
      eb = (c < 2);
      n_checks++;
      if ({GNT, DONE, BUSY} !== {eg, ed, eb}) begin
        n_fail++;
        $display("FAIL dur_zero c=%0d: GNT=%b DONE=%b BUSY=%b, want %b %b %b", c, GNT, DONE, BUSY, eg, ed, eb);
      end
      if (c == 0) REQ = 4'b0000;
    end
  endtask

  task automatic test_abort();
    logic [3:0] eg_t[8] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic [3:0] ed_t[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
    logic       eb_t[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    REQ = 4'b1001; DUR = 32'h0A000002;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      n_checks++;
      if ({GNT, DONE, BUSY} !== {eg_t[c], ed_t[c], eb_t[c]}) begin
        n_fail++;
        $display("FAIL abort c=%0d: GNT=%b DONE=%b BUSY=%b, want %b %b %b", c, GNT, DONE, BUSY, eg_t[c], ed_t[c], eb_t[c]);
      end
      if (c == 2) ABORT = 1'b1;
      if (c == 3) ABORT = 1'b0;
      if (c == 4) REQ = 4'b0000;
    end
  endtask

  task automatic test_abort_last();
    logic [3:0] eg;
    logic       eb;
    REQ = 4'b0010; DUR = 32'h00000200;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      eg = (c < 2) ? 4'b0010 : 4'b0000;
      eb = (c < 2);
      n_checks++;
      if ({GNT, DONE, BUSY} !== {eg, 4'b0000, eb}) begin
        n_fail++;
        $display("FAIL abort_on_last c=%0d: GNT=%b DONE=%b BUSY=%b, want %b 0000 %b", c, GNT, DONE, BUSY, eg, eb);
      end
      if (c == 0) REQ = 4'b0000;
      if (c == 1) ABORT = 1'b1;
      if (c == 2) ABORT = 1'b0;
    end
  endtask

  task automatic test_abort_idle_fin();
    logic [3:0] eg, ed;
    logic       eb;
    REQ = 4'b0100; DUR = 32'h00010000; ABORT = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      eg = (c == 0) ? 4'b0100 : 4'b0000;
      ed = (c == 1) ? 4'b0100 : 4'b0000;
      eb = (c < 2);
      n_checks++;
      if ({GNT, DONE, BUSY} !== {eg, ed, eb}) begin
        n_fail++;
        $display("FAIL abort_idle_fin c=%0d: GNT=%b DONE=%b BUSY=%b, want %b %b %b", c, GNT, DONE, BUSY, eg, ed, eb);
      end
      if (c == 0) begin ABORT = 1'b0; REQ = 4'b0000; end
      if (c == 1) ABORT = 1'b1;
      if (c == 2) ABORT = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    REQ = 4'b0001; DUR = 32'h00000005;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_checks++;
      if ({GNT, DONE, BUSY} !== {4'b0001, 4'b0000, 1'b1}) begin
        n_fail++;
        $display("FAIL mid_reset_run c=%0d: GNT=%b DONE=%b BUSY=%b, want 0001 0000 1", c, GNT, DONE, BUSY);
      end
      if (c == 0) REQ = 4'b0000;
    end
    #2 N_RESET = 1'b0;
    #1;
    n_checks++;
    if ({GNT, DONE, BUSY} !== 9'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: GNT=%b DONE=%b BUSY=%b, want 0000 0000 0", GNT, DONE, BUSY);
    end
    @(negedge CLK);
    N_RESET = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_checks++;
      if ({GNT, DONE, BUSY} !== 9'b0) begin
        n_fail++;
        $display("FAIL mid_reset_after c=%0d: GNT=%b DONE=%b BUSY=%b, want 0000 0000 0", c, GNT, DONE, BUSY);
      end
    end
  endtask

  task automatic test_prio();
`ifdef TIMER_SCHED_FIXED_PRIO_EN
    int ord[4] = '{0, 0, 0, 0};
`else
    int ord[4] = '{0, 1, 3, 0};
`endif
    int         w, ph;
    logic [3:0] eg, ed;
    logic       eb;
    N_RESET = 1'b0;
    @(negedge CLK);
    N_RESET = 1'b1; REQ = 4'b1011; DUR = 32'h01010101;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      w  = ord[c / 3];
      ph = c % 3;
      eg = (ph == 0) ? (4'b0001 << w) : 4'b0000;
      ed = (ph == 1) ? (4'b0001 << w) : 4'b0000;
      eb = (ph < 2);
      n_checks++;
      if ({GNT, DONE, BUSY} !== {eg, ed, eb}) begin
        n_fail++;
        $display("FAIL prio_1011 c=%0d: GNT=%b DONE=%b BUSY=%b, want %b %b %b", c, GNT, DONE, BUSY, eg, ed, eb);
      end
      if (c == 9) REQ = 4'b0000;
    end
  endtask

  initial begin
    test_reset();
    wait_idle();
    test_single();
    test_rr();
    test_dur0();
    test_abort();
    test_abort_last();
    test_abort_idle_fin();
    test_mid_reset();
    test_prio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
